// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver paced by an external UART_CLK_DIV mark strobe.
// Optional parity stage is compiled in when the macro UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_div_mark,
  output logic                 o_div_clear,
  output logic                 o_div_enable,
  output logic [DATA_BITS-1:0] o_dout,
  output logic                 o_dout_vld,
  output logic                 o_frame_error,
  output logic                 o_parity_error
);

  localparam int unsigned     CntW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_dout;
  logic                  r_dout_vld;
  logic                  r_frame_err;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic                  r_rx_d;
  logic                  w_start_edge;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bad;
  logic                  r_parity_err;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_start_edge = r_rx_d & ~r_rx_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_dout_vld   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
`ifdef UART_RX_PARITY_EN
          r_par_bad <= 1'b0;
`endif
          if (w_start_edge) r_state <= StStart;
        end
        StStart: begin
          // A line back high at mid start bit is a glitch: drop it silently.
          if (i_div_mark) begin
            if (!r_rx_s) begin
              r_bit_cnt <= '0;
              r_state   <= StData;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StData: begin
          if (i_div_mark) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LastBit) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + CntW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (i_div_mark) begin
            r_par_bad <= (^r_shift) ^ PARITY_ODD ^ r_rx_s;
            r_state   <= StStop;
          end
        end
`endif
        StStop: begin
          // Returning to idle mid stop bit lets a back-to-back start edge be caught.
          if (i_div_mark) begin
            r_state <= StIdle;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_bad;
            if (r_rx_s && !r_par_bad) begin
`else
            if (r_rx_s) begin
`endif
              r_dout     <= r_shift;
              r_dout_vld <= 1'b1;
            end
            if (!r_rx_s) r_frame_err <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_div_clear   = (r_state == StIdle);
  assign o_div_enable  = (r_state != StIdle);
  assign o_dout        = r_dout;
  assign o_dout_vld    = r_dout_vld;
  assign o_frame_error = r_frame_err;

`ifdef UART_RX_PARITY_EN
  assign o_parity_error = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
  assign o_parity_error      = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver stage downstream of UART_CLK_DIV. It consumes the divider's DIV_MARK and controls the divider through DIV_CLEAR/DIV_ENABLE. The divider is configured with DIV_MARK_POS ≈ DIV_MAX_VAL/2, so each mark lands mid-bit. The block deserialises 8N1-style frames (LSB first) into parallel bytes, with a one-cycle valid pulse and error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd; ignored otherwise

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
RX  input  1  serial line, asynchronous to CLK, idles high
DIV_MARK  input  1  mid-bit sample strobe from UART_CLK_DIV
DIV_CLEAR  output  1  divider counter clear
DIV_ENABLE  output  1  divider counter enable
DOUT  output  DATA_BITS  received data word, held until the next good frame
DOUT_VLD  output  1  one-cycle pulse: DOUT updated
FRAME_ERROR  output  1  one-cycle pulse: stop bit sampled low
PARITY_ERROR  output  1  one-cycle pulse: parity mismatch (tied 0 without macro)

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; all outputs 0 except DIV_CLEAR=1.
  - DOUT=0.
  - Synchroniser flops and edge register reset to 1 (line idle).
- RX input path:
  - 2-FF synchroniser gives rx_s; one more register gives rx_d.
  - Start edge = rx_d & ~rx_s.
  - Start detection therefore lags the line by 3 CLK.
- DIV_CLEAR and DIV_ENABLE are a Moore decode of the state register:
  - IDLE: CLEAR=1, ENABLE=0.
  - All other states: CLEAR=0, ENABLE=1.
- States:
  - IDLE: on start edge -> START.
  - START: on DIV_MARK, if rx_s=0 -> DATA with bit_cnt=0. If rx_s=1 -> IDLE (glitch or false start, no flags).
  - DATA: on each DIV_MARK, shift rx_s into the MSB of the shift register (right shift, so LSB-first arrival ends up in correct order) and increment bit_cnt. On the DIV_MARK where bit_cnt=DATA_BITS-1 -> PARITY if the macro is defined, else STOP.
  - PARITY (macro only): on DIV_MARK, capture the parity bit -> STOP.
  - STOP: on DIV_MARK -> IDLE, and:
    - rx_s=1 and no parity error: DOUT<=shift register, DOUT_VLD=1 for the next cycle.
    - rx_s=0: FRAME_ERROR=1 for one cycle; DOUT unchanged; DOUT_VLD stays 0.
- Latency: DOUT/DOUT_VLD/flags are registered and appear in the cycle after the stop-bit DIV_MARK cycle.
- bit_cnt width is $clog2(DATA_BITS); no wrap beyond DATA_BITS-1.
- Back-to-back frames:
  - The return to IDLE happens mid-stop-bit, so a start edge arriving immediately after the stop bit is caught.
  - On the IDLE cycle, DIV_CLEAR re-zeros the divider, so the next frame's marks are re-aligned to its own start edge.
- No backpressure and no overrun detection: the consumer must take DOUT within one frame time.
- DIV_MARK outside START/DATA/PARITY/STOP is ignored.
- A start edge while not in IDLE is ignored.
- RST asserted mid-frame aborts immediately; no DOUT_VLD or flags are issued for the aborted frame.
- A line held low permanently: each STOP sample gives FRAME_ERROR. The block then stays in IDLE until a high-to-low edge is seen, so there is no repeated error spam.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is start + DATA_BITS + parity + stop.
  - Expected parity = ^data XOR PARITY_ODD; mismatch versus the sampled bit flags an error.
  - On the STOP mark with a parity mismatch: PARITY_ERROR pulses, DOUT_VLD is suppressed, DOUT is held.
  - If the stop bit is also low, FRAME_ERROR pulses in the same cycle.
- Undefined:
  - No PARITY state; PARITY_ERROR is constant 0; PARITY_ODD is unused.

Test Plan:
- Bench setup: UART_CLK_DIV with DIV_MAX_VAL=16, DIV_MARK_POS=8; bit period = 16 CLK.
- Reset and idle: hold RX=1, pulse RST mid-run -> DIV_CLEAR=1, DIV_ENABLE=0, DOUT=0x00, no pulses for 200 cycles.
- Single byte: send 0xA5 (8N1) -> exactly one DOUT_VLD pulse, DOUT=0xA5, pulse ~8 CLK into the stop bit, FRAME_ERROR=0.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with zero idle gap -> three DOUT_VLD pulses in order with the matching values; no errors.
- False start: drive RX low for 4 CLK only -> state returns to IDLE at the first mark; no DOUT_VLD or FRAME_ERROR; next valid 0x5A is received correctly.
- Framing error: send 0x81 with stop bit low -> FRAME_ERROR pulses once, DOUT_VLD=0, DOUT keeps the previous value.
- Parity/reset with UART_RX_PARITY_EN, PARITY_ODD=0:
  - 0x07 with parity bit 1 -> DOUT_VLD, DOUT=0x07.
  - 0x07 with parity bit 0 -> PARITY_ERROR pulse, no DOUT_VLD.
  - RST asserted during data bit 4 -> no output pulses for that frame; immediate DIV_CLEAR=1.
